vendo_dispense_ctrl: RTL and testbench

VENDO_DISPENSE_CTRL -- requirements
Module: vendo_dispense_ctrl

---
 rtl/vendo_pkg.sv | 22 ++
 rtl/sns_sync.sv | 32 +++
 rtl/vendo_dispense_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vendo_dispense_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vendo_pkg.sv
// vendo_pkg: definitions shared by the vending FSM and the dispense controller.
//   state_e         - dispense controller state encodings (visible on cstate)
//   *Default        - default timing parameters for vendo_dispense_ctrl
package vendo_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StVend     = 3'd1,
    StKick     = 3'd2,
    StWaitCoin = 3'd3,
    StDone     = 3'd4,
    StFault    = 3'd5
  } state_e;

  localparam int unsigned MotorToDefault = 16;
  localparam int unsigned KickLenDefault = 2;
  localparam int unsigned CoinToDefault  = 8;

  // Width of the change-count field.
  localparam int unsigned ChangeW = 3;

endpackage

// File: rtl/sns_sync.sv
// sns_sync: 2-flop synchronizer plus falling-edge detector for an active-low,
// asynchronous sensor pin.
//   clk   - clock
//   reset - synchronous active-low reset; flops return to the idle (high) level
//   sns   - raw active-low sensor pin
//   fall  - one-cycle event on each synchronized high-to-low transition
module sns_sync (
  input  logic clk,
  input  logic reset,
  input  logic sns,
  output logic fall
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= sns;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Both terms come straight from flops, so the event is glitch-free and is
  // acted on by the FSM at the third clock edge after the pin falls.
  assign fall = hist_q & ~sync2_q;

endmodule

// File: rtl/vendo_dispense_ctrl.sv
// vendo_dispense_ctrl: drives the product motor and coin hopper for one
// vending job (dispense, change return, or both in that order).
//   clk          - clock, rising edge
//   reset        - synchronous active-low reset
//   disp         - product dispense request (sampled in IDLE only)
//   change       - change-return request (sampled in IDLE only)
//   change_cnt   - coins to return, latched with the request
//   prod_sns     - active-low async product-drop sensor
//   coin_sns     - active-low async coin-out sensor
//   motor_on     - product motor drive
//   hopper_kick  - coin hopper eject pulse, KICK_LEN cycles per coin
//   busy         - high whenever not IDLE
//   done         - one-cycle pulse on successful completion
//   fault        - high while in FAULT
//   cstate       - current state encoding
// Define VENDO_WATCHDOG_EN to add the motor/coin timeouts and the FAULT state;
// without it VEND and WAIT_COIN wait indefinitely and fault is tied low.
module vendo_dispense_ctrl
  import vendo_pkg::*;
#(
  parameter int unsigned MOTOR_TO = MotorToDefault,
  parameter int unsigned KICK_LEN = KickLenDefault,
  parameter int unsigned COIN_TO  = CoinToDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp,
  input  logic               change,
  input  logic [ChangeW-1:0] change_cnt,
  input  logic               prod_sns,
  input  logic               coin_sns,
  output logic               motor_on,
  output logic               hopper_kick,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [2:0]         cstate
);

  if (MOTOR_TO < 1 || KICK_LEN < 1 || COIN_TO < 1) begin : gen_bad_param
    $error("vendo_dispense_ctrl: MOTOR_TO, KICK_LEN and COIN_TO must be >= 1");
  end

  localparam int unsigned KickW = $clog2(KICK_LEN + 1);

  state_e             state_q, state_d;
  logic [ChangeW-1:0] coins_q, coins_d;
  logic [KickW-1:0]   kick_cnt_q, kick_cnt_d;
  logic               prod_ev, coin_ev;
  logic               motor_q, kick_q, busy_q, done_q;

`ifdef VENDO_WATCHDOG_EN
  localparam int unsigned WdMax = (MOTOR_TO > COIN_TO) ? MOTOR_TO : COIN_TO;
  localparam int unsigned WdW   = $clog2(WdMax + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           fault_q;
`endif

  sns_sync u_prod_sync (
    .clk   (clk),
    .reset (reset),
    .sns   (prod_sns),
    .fall  (prod_ev)
  );

  sns_sync u_coin_sync (
    .clk   (clk),
    .reset (reset),
    .sns   (coin_sns),
    .fall  (coin_ev)
  );

  always_comb begin
    state_d    = state_q;
    coins_d    = coins_q;
    kick_cnt_d = kick_cnt_q;
`ifdef VENDO_WATCHDOG_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      StIdle: begin
        kick_cnt_d = '0;
`ifdef VENDO_WATCHDOG_EN
        wd_d       = '0;
`endif
        if (disp) begin
          state_d = StVend;
          coins_d = change ? change_cnt : '0;
        end else if (change && (change_cnt != '0)) begin
          state_d = StKick;
          coins_d = change_cnt;
        end
      end
      StVend: begin
        // A product event wins over a timeout in the same cycle.
        if (prod_ev) begin
          state_d    = (coins_q != '0) ? StKick : StDone;
          kick_cnt_d = '0;
        end
`ifdef VENDO_WATCHDOG_EN
        else if (wd_q == WdW'(MOTOR_TO - 1)) begin
          state_d = StFault;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StKick: begin
        if (kick_cnt_q == KickW'(KICK_LEN - 1)) begin
          state_d    = StWaitCoin;
          kick_cnt_d = '0;
`ifdef VENDO_WATCHDOG_EN
          wd_d       = '0;
`endif
        end else begin
          kick_cnt_d = kick_cnt_q + 1'b1;
        end
      end
      StWaitCoin: begin
        // Coin events are only consumed here; elsewhere they are dropped.
        if (coin_ev) begin
          coins_d    = coins_q - 1'b1;
          kick_cnt_d = '0;
          state_d    = (coins_q != ChangeW'(1)) ? StKick : StDone;
        end
`ifdef VENDO_WATCHDOG_EN
        else if (wd_q == WdW'(COIN_TO - 1)) begin
          state_d = StFault;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with cstate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      coins_q    <= '0;
      kick_cnt_q <= '0;
      motor_q    <= 1'b0;
      kick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coins_q    <= coins_d;
      kick_cnt_q <= kick_cnt_d;
      motor_q    <= (state_d == StVend);
      kick_q     <= (state_d == StKick);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

`ifdef VENDO_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= (state_d == StFault);
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign motor_on    = motor_q;
  assign hopper_kick = kick_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cstate      = state_q;

endmodule

// File: tb/tb_vendo_dispense_ctrl.sv
// Directed testbench for vendo_dispense_ctrl with default parameters.
module tb_vendo_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       disp = 1'b0;
  logic       change = 1'b0;
  logic [2:0] change_cnt = 3'd0;
  logic       prod_sns = 1'b1;
  logic       coin_sns = 1'b1;
  logic       motor_on, hopper_kick, busy, done, fault;
  logic [2:0] cstate;

  int n_checks = 0;
  int n_pass   = 0;

  // Activity totals sampled on the falling edge.
  int  kick_cyc = 0, kick_pul = 0, done_cnt = 0, overlap = 0;
  logic kick_prev = 1'b0;

  always #5 clk = ~clk;

  vendo_dispense_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .disp        (disp),
    .change      (change),
    .change_cnt  (change_cnt),
    .prod_sns    (prod_sns),
    .coin_sns    (coin_sns),
    .motor_on    (motor_on),
    .hopper_kick (hopper_kick),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .cstate      (cstate)
  );

  always @(negedge clk) begin
    if (hopper_kick) kick_cyc++;
    if (hopper_kick && !kick_prev) kick_pul++;
    kick_prev = hopper_kick;
    if (done) done_cnt++;
    if (motor_on && hopper_kick) overlap++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle coin pulse; the event is acted on at the third edge.
  task automatic coin_pulse(input string tag, input int next_state);
    coin_sns = 1'b0;
    step();
    coin_sns = 1'b1;
    step();
    check({tag, "_wait"}, cstate, 3);
    step();
    check({tag, "_next"}, cstate, next_state);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cstate"}, cstate, 0);
    check({tag, "_outs"}, {motor_on, hopper_kick, busy, done, fault}, 0);
  endtask

  int k0, p0, d0;

  initial begin
    // Reset
    step();
    step();
    check_idle("reset");
    reset = 1'b1;
    step();
    check_idle("post_reset");

    // Dispense only
    k0 = kick_cyc; d0 = done_cnt;
    disp = 1'b1;
    step();
    disp = 1'b0;
    check("disp_vend", cstate, 1);
    check("disp_motor", motor_on, 1);
    check("disp_busy", busy, 1);
    step(); step(); step();
    prod_sns = 1'b0;
    step(); step();
    check("disp_still_vend", cstate, 1);
    check("disp_motor_hold", motor_on, 1);
    step();
    prod_sns = 1'b1;
    check("disp_done_state", cstate, 4);
    check("disp_done_pulse", done, 1);
    check("disp_motor_off", motor_on, 0);
    step();
    check_idle("disp_end");
    check("disp_no_kick", kick_cyc - k0, 0);
    check("disp_done_cnt", done_cnt - d0, 1);

    // Change of 3
    k0 = kick_cyc; p0 = kick_pul; d0 = done_cnt;
    change = 1'b1; change_cnt = 3'd3;
    step();
    change = 1'b0; change_cnt = 3'd0;
    check("chg_kick", cstate, 2);
    check("chg_kick_out", hopper_kick, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        step();
        check("chg_kick2", hopper_kick, 1);
      end else begin
        step();
      end
      step();
      check("chg_wait", cstate, 3);
      coin_pulse("chg_coin", (i < 2) ? 2 : 4);
    end
    check("chg_done_pulse", done, 1);
    step();
    check_idle("chg_end");
    check("chg_pulses", kick_pul - p0, 3);
    check("chg_kick_cycles", kick_cyc - k0, 6);
    check("chg_done_cnt", done_cnt - d0, 1);

    // Combined dispense + 1 coin; extra disp pulses are ignored
    k0 = kick_cyc; p0 = kick_pul; d0 = done_cnt;
    disp = 1'b1; change = 1'b1; change_cnt = 3'd1;
    step();
    change = 1'b0; change_cnt = 3'd0;
    check("comb_vend", cstate, 1);
    prod_sns = 1'b0;
    step();
    disp = 1'b0;
    step();
    check("comb_still_vend", cstate, 1);
    step();
    prod_sns = 1'b1;
    check("comb_kick", cstate, 2);
    step();
    check("comb_kick_hold", cstate, 2);
    step();
    check("comb_wait", cstate, 3);
    disp = 1'b1;
    coin_pulse("comb_coin", 4);
    disp = 1'b0;
    step();
    check("comb_idle", cstate, 0);
    step();
    check_idle("comb_not_queued");
    check("comb_pulses", kick_pul - p0, 1);
    check("comb_done_cnt", done_cnt - d0, 1);

    // Reset mid-KICK
    d0 = done_cnt;
    change = 1'b1; change_cnt = 3'd2;
    step();
    change = 1'b0; change_cnt = 3'd0;
    check("rst_in_kick", cstate, 2);
    reset = 1'b0;
    step();
    check_idle("rst_abort");
    reset = 1'b1;
    step();
    step();
    check_idle("rst_no_resume");
    check("rst_no_done", done_cnt - d0, 0);

    // change with change_cnt = 0
    change = 1'b1; change_cnt = 3'd0;
    step();
    change = 1'b0;
    check_idle("chg0");
    step();
    check_idle("chg0_stay");

    // Watchdog behaviour
    disp = 1'b1;
    step();
    disp = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("wd_vend16", cstate, 1);
    step();
`ifdef VENDO_WATCHDOG_EN
    check("wd_fault_state", cstate, 5);
    check("wd_fault", fault, 1);
    check("wd_motor_off", motor_on, 0);
    disp = 1'b1;
    step(); step(); step();
    disp = 1'b0;
    check("wd_fault_hold", cstate, 5);
    check("wd_fault_hold_out", {fault, motor_on, hopper_kick}, 3'b100);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_idle("wd_reset");
`else
    for (int i = 0; i < 8; i++) step();
    check("nowd_vend", cstate, 1);
    check("nowd_fault", fault, 0);
    prod_sns = 1'b0;
    step(); step(); step();
    prod_sns = 1'b1;
    check("nowd_done", cstate, 4);
    step();
    check_idle("nowd_end");
`endif

    check("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
